dsp_mult_shift_acc: RTL and testbench

Parametrised, pipelined multiply-accumulate block that generalises the fixed multiply-add-shifted-operand datapath.
- Per valid beat it computes a*b + (a << shift), and optionally adds the running accumulator.
- Accumulator can be cleared/loaded per beat; optional subtract mode.
- Sits in the DSP datapath as the behavioural model/wrapper mapped onto the DSP MULTADD primitive, driven by FIR/filter controllers.

---
 rtl/dsp_mult_shift_acc.sv | 259 +++++++++++++++++++++++++
 tb/tb_dsp_mult_shift_acc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mult_shift_acc.sv
// ---------------------------------------------------------------------------
// dsp_mult_shift_acc
//
// Pipelined multiply / shifted-add / accumulate datapath. Each valid beat
// forms term = a*b + (a << shift) and either loads it into the accumulator
// or adds/subtracts it to/from the running value. This is the behavioural
// model of the DSP MULTADD primitive used by the FIR/filter controllers.
//
// Parameters:
//   A_W      width of operand a
//   B_W      width of operand b
//   SHIFT_W  width of the shift amount
//   Z_W      accumulator / output width (must be >= A_W + B_W)
//   SIGNED   1 = a and b are two's complement, 0 = unsigned
//
// Ports:
//   clk        clock, everything on the rising edge
//   reset      synchronous active-high reset
//   in_valid   input beat qualifier
//   a, b       multiplier operands
//   shift      left-shift amount applied to a for the added operand
//   acc_en     1 = combine with accumulator, 0 = replace accumulator
//   sub        1 = subtract the beat's term instead of adding it
//   z_out      accumulator value
//   out_valid  z_out was updated by a beat on the last edge
//   overflow   sticky flag, set when a term or result left the Z_W range
//
// Latency is 3: a beat captured at edge N updates z_out at edge N+3.
// Register levels: input (S1), multiplier/shifter (S2), term (S2 term),
// accumulator (S3). Throughput is one beat per clock, no backpressure.
//
// Optional feature, macro DSP_MULT_SHIFT_ACC_SATURATE_EN:
//   defined   - term and accumulator clamp to the representable range
//   undefined - modular wrap, no clamp logic
// The overflow flag behaves identically in both builds.
// ---------------------------------------------------------------------------
module dsp_mult_shift_acc #(
  parameter int A_W     = 20,
  parameter int B_W     = 18,
  parameter int SHIFT_W = 6,
  parameter int Z_W     = 38,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               acc_en,
  input  logic               sub,
  output logic [Z_W-1:0]     z_out,
  output logic               out_valid,
  output logic               overflow
);

  localparam bit          IS_SIGNED = (SIGNED != 0);
  localparam logic [31:0] Z_W_U     = Z_W;

`ifdef DSP_MULT_SHIFT_ACC_SATURATE_EN
  localparam logic [Z_W-1:0] UMAX = {Z_W{1'b1}};
  localparam logic [Z_W-1:0] SMAX = {1'b0, {(Z_W-1){1'b1}}};
  localparam logic [Z_W-1:0] SMIN = {1'b1, {(Z_W-1){1'b0}}};
`endif

  // -------------------------------------------------------------------------
  // S1: input capture
  // -------------------------------------------------------------------------
  logic               s1_valid;
  logic [A_W-1:0]     s1_a;
  logic [B_W-1:0]     s1_b;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s1_acc_en;
  logic               s1_sub;

  // Operand register; everything downstream works from these copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_shift  <= '0;
      s1_acc_en <= 1'b0;
      s1_sub    <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_shift  <= shift;
      s1_acc_en <= acc_en;
      s1_sub    <= sub;
    end
  end

  // -------------------------------------------------------------------------
  // S2: multiplier and shifter
  // -------------------------------------------------------------------------
  logic           a_sign;
  logic           b_sign;
  logic [Z_W-1:0] a_ext;
  logic [Z_W-1:0] b_ext;
  logic [Z_W-1:0] prod_c;
  logic [Z_W-1:0] sh_c;

  // Operands are widened to Z_W first. Because Z_W >= A_W+B_W the full
  // product fits, so a Z_W-bit multiply of the sign-extended operands gives
  // the exact two's-complement product and the same logic serves both modes.
  // Shifts of Z_W or more push every bit of a out, so sh is forced to zero.
  always_comb begin
    a_sign = IS_SIGNED & s1_a[A_W-1];
    b_sign = IS_SIGNED & s1_b[B_W-1];
    a_ext  = {{(Z_W-A_W){a_sign}}, s1_a};
    b_ext  = {{(Z_W-B_W){b_sign}}, s1_b};
    prod_c = a_ext * b_ext;
    if (32'(s1_shift) >= Z_W_U) begin
      sh_c = '0;
    end else begin
      sh_c = a_ext << s1_shift;
    end
  end

  logic           s2_valid;
  logic [Z_W-1:0] s2_prod;
  logic [Z_W-1:0] s2_sh;
  logic           s2_acc_en;
  logic           s2_sub;

  // Multiplier output register, mirrors the primitive's product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_sh     <= '0;
      s2_acc_en <= 1'b0;
      s2_sub    <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_prod   <= prod_c;
      s2_sh     <= sh_c;
      s2_acc_en <= s1_acc_en;
      s2_sub    <= s1_sub;
    end
  end

  // -------------------------------------------------------------------------
  // S2 term: prod + sh with range detection
  // -------------------------------------------------------------------------
  logic [Z_W:0]   term_sum;
  logic           term_ovf;
  logic [Z_W-1:0] term_c;

  // Unsigned overflow is the carry out; signed overflow is two same-sign
  // addends producing a result of the other sign.
  always_comb begin
    term_sum = {1'b0, s2_prod} + {1'b0, s2_sh};
    if (IS_SIGNED) begin
      term_ovf = (s2_prod[Z_W-1] == s2_sh[Z_W-1]) &&
                 (term_sum[Z_W-1] != s2_prod[Z_W-1]);
    end else begin
      term_ovf = term_sum[Z_W];
    end
    term_c = term_sum[Z_W-1:0];
`ifdef DSP_MULT_SHIFT_ACC_SATURATE_EN
    // In signed mode both addends share the sign of prod on overflow,
    // so that sign picks the clamp direction.
    if (term_ovf) begin
      if (IS_SIGNED) begin
        term_c = s2_prod[Z_W-1] ? SMIN : SMAX;
      end else begin
        term_c = UMAX;
      end
    end
`endif
  end

  logic           t_valid;
  logic [Z_W-1:0] t_term;
  logic           t_ovf;
  logic           t_acc_en;
  logic           t_sub;

  // Term register feeding the accumulator stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_valid  <= 1'b0;
      t_term   <= '0;
      t_ovf    <= 1'b0;
      t_acc_en <= 1'b0;
      t_sub    <= 1'b0;
    end else begin
      t_valid  <= s2_valid;
      t_term   <= term_c;
      t_ovf    <= term_ovf;
      t_acc_en <= s2_acc_en;
      t_sub    <= s2_sub;
    end
  end

  // -------------------------------------------------------------------------
  // S3: accumulator
  // -------------------------------------------------------------------------
  logic [Z_W-1:0] base;
  logic [Z_W:0]   res_full;
  logic           res_ovf;
  logic [Z_W-1:0] res_c;

  // base reads z_out directly, so a beat sees the value written by the beat
  // one cycle ahead of it and back-to-back accumulation needs no bubble.
  // Bit Z_W of the widened add/subtract is carry (add) or borrow (sub).
  always_comb begin
    base = t_acc_en ? z_out : '0;
    if (t_sub) begin
      res_full = {1'b0, base} - {1'b0, t_term};
    end else begin
      res_full = {1'b0, base} + {1'b0, t_term};
    end
    if (IS_SIGNED) begin
      if (t_sub) begin
        res_ovf = (base[Z_W-1] != t_term[Z_W-1]) &&
                  (res_full[Z_W-1] != base[Z_W-1]);
      end else begin
        res_ovf = (base[Z_W-1] == t_term[Z_W-1]) &&
                  (res_full[Z_W-1] != base[Z_W-1]);
      end
    end else begin
      res_ovf = res_full[Z_W];
    end
    res_c = res_full[Z_W-1:0];
`ifdef DSP_MULT_SHIFT_ACC_SATURATE_EN
    // A signed overflow always runs away from zero in the direction of
    // base's sign; unsigned overflow is a carry (add) or a borrow (sub).
    if (res_ovf) begin
      if (IS_SIGNED) begin
        res_c = base[Z_W-1] ? SMIN : SMAX;
      end else begin
        res_c = t_sub ? '0 : UMAX;
      end
    end
`endif
  end

  // Only valid beats touch z_out; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= t_valid;
      if (t_valid) begin
        z_out <= res_c;
        if (t_ovf || res_ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mult_shift_acc.sv
// ---------------------------------------------------------------------------
// tb_dsp_mult_shift_acc
//
// Self-checking bench for dsp_mult_shift_acc. An unsigned instance is driven
// from a vector table, hand-written latency/reset sequences and a random run
// checked against a wide-integer reference model; expected results go into a
// scoreboard queue when a beat is driven and are popped whenever out_valid
// is seen. A second, signed instance covers the two's-complement mode.
// Expectations follow DSP_MULT_SHIFT_ACC_SATURATE_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dsp_mult_shift_acc;

  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int SHIFT_W = 6;
  localparam int Z_W     = 38;

`ifdef DSP_MULT_SHIFT_ACC_SATURATE_EN
  localparam bit             SAT        = 1'b1;
  localparam logic [Z_W-1:0] EXP_UNDER  = 38'h0;
  localparam logic [Z_W-1:0] EXP_BIG2   = 38'h3FFFFFFFFF;
  localparam logic [Z_W-1:0] EXP_CARRY  = 38'h3FFFFFFFFF;
  localparam logic [Z_W-1:0] EXP_S_OVF  = 38'h1FFFFFFFFF;
`else
  localparam bit             SAT        = 1'b0;
  localparam logic [Z_W-1:0] EXP_UNDER  = 38'h3FFFFFFFB0;
  localparam logic [Z_W-1:0] EXP_BIG2   = 38'h3FFFD80002;
  localparam logic [Z_W-1:0] EXP_CARRY  = 38'h0;
  localparam logic [Z_W-1:0] EXP_S_OVF  = 38'h2FFFF20001;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic [SHIFT_W-1:0] shift;
  logic               acc_en;
  logic               sub;
  logic [Z_W-1:0]     z_out;
  logic               out_valid;
  logic               overflow;

  logic               s_in_valid;
  logic [A_W-1:0]     s_a;
  logic [B_W-1:0]     s_b;
  logic [SHIFT_W-1:0] s_shift;
  logic               s_acc_en;
  logic               s_sub;
  logic [Z_W-1:0]     s_z_out;
  logic               s_out_valid;
  logic               s_overflow;

  dsp_mult_shift_acc #(
    .A_W(A_W), .B_W(B_W), .SHIFT_W(SHIFT_W), .Z_W(Z_W), .SIGNED(0)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .shift(shift), .acc_en(acc_en), .sub(sub), .z_out(z_out),
    .out_valid(out_valid), .overflow(overflow)
  );

  dsp_mult_shift_acc #(
    .A_W(A_W), .B_W(B_W), .SHIFT_W(SHIFT_W), .Z_W(Z_W), .SIGNED(1)
  ) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .a(s_a), .b(s_b),
    .shift(s_shift), .acc_en(s_acc_en), .sub(s_sub), .z_out(s_z_out),
    .out_valid(s_out_valid), .overflow(s_overflow)
  );

  typedef struct {
    logic [Z_W-1:0] z;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic               do_reset;
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic [SHIFT_W-1:0] shift;
    logic               acc_en;
    logic               sub;
    logic [Z_W-1:0]     z;
    logic               ovf;
  } vec_t;

  exp_t           sb_q[$];
  vec_t           vecs[12];
  int             tests_run    = 0;
  int             tests_failed = 0;
  logic [Z_W-1:0] model_z;
  logic           model_ov;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; a valid beat queues its expected result.
  task automatic applyStimulus(input logic v, input logic [A_W-1:0] ai,
                               input logic [B_W-1:0] bi,
                               input logic [SHIFT_W-1:0] si, input logic ae,
                               input logic su, input logic [Z_W-1:0] ez,
                               input logic eo);
    in_valid = v;
    a        = ai;
    b        = bi;
    shift    = si;
    acc_en   = ae;
    sub      = su;
    if (v) sb_q.push_back('{z: ez, ovf: eo});
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset      = 1'b1;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    sb_q.delete();
    model_z  = '0;
    model_ov = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, " drain"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Reference model using 128-bit integers rather than Z_W-bit datapaths.
  task automatic modelBeat(input logic [A_W-1:0] ai, input logic [B_W-1:0] bi,
                           input logic [SHIFT_W-1:0] si, input logic ae,
                           input logic su, output logic [Z_W-1:0] ez,
                           output logic eo);
    logic [127:0] lim, prod, shv, term, base, res;
    lim  = 128'd1 << Z_W;
    prod = 128'(ai) * 128'(bi);
    if (int'(si) >= Z_W) shv = '0;
    else shv = (128'(ai) << si) & (lim - 128'd1);
    term = prod + shv;
    if (term >= lim) begin
      model_ov = 1'b1;
      term = SAT ? lim - 128'd1 : term - lim;
    end
    base = ae ? 128'(model_z) : 128'd0;
    if (su) begin
      if (term > base) begin
        model_ov = 1'b1;
        res = SAT ? 128'd0 : base + lim - term;
      end else begin
        res = base - term;
      end
    end else begin
      res = base + term;
      if (res >= lim) begin
        model_ov = 1'b1;
        res = SAT ? lim - 128'd1 : res - lim;
      end
    end
    model_z = res[Z_W-1:0];
    ez = model_z;
    eo = model_ov;
  endtask

  task automatic signedBeat(input string name, input logic [A_W-1:0] ai,
                            input logic [B_W-1:0] bi,
                            input logic [SHIFT_W-1:0] si, input logic ae,
                            input logic su, input logic [Z_W-1:0] ez,
                            input logic eo);
    int n = 0;
    s_in_valid = 1'b1;
    s_a        = ai;
    s_b        = bi;
    s_shift    = si;
    s_acc_en   = ae;
    s_sub      = su;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    while (!s_out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, " valid"}, 64'(s_out_valid), 64'd1);
    checkOutput({name, " z"}, 64'(s_z_out), 64'(ez));
    checkOutput({name, " ovf"}, 64'(s_overflow), 64'(eo));
  endtask

  // Scoreboard: every out_valid must match the oldest outstanding beat.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected out_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb z_out", 64'(z_out), 64'(e.z));
        checkOutput("sb overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic               rv;
    logic [A_W-1:0]     ra;
    logic [B_W-1:0]     rb;
    logic [SHIFT_W-1:0] rs;
    logic               rae, rsu;
    logic [Z_W-1:0]     ez;
    logic               eo;

    vecs[0]  = '{1'b0, 20'd255,    18'd1,       6'd1,  1'b0, 1'b0, 38'd765,  1'b0};
    vecs[1]  = '{1'b0, 20'd255,    18'd1,       6'd1,  1'b1, 1'b0, 38'd1530, 1'b0};
    vecs[2]  = '{1'b0, 20'd255,    18'd1,       6'd1,  1'b1, 1'b0, 38'd2295, 1'b0};
    vecs[3]  = '{1'b0, 20'd255,    18'd1,       6'd1,  1'b1, 1'b0, 38'd3060, 1'b0};
    vecs[4]  = '{1'b0, 20'd50,     18'd1,       6'd0,  1'b0, 1'b0, 38'd100,  1'b0};
    vecs[5]  = '{1'b0, 20'd10,     18'd3,       6'd0,  1'b1, 1'b1, 38'd60,   1'b0};
    vecs[6]  = '{1'b0, 20'd5,      18'd7,       6'd38, 1'b0, 1'b0, 38'd35,   1'b0};
    vecs[7]  = '{1'b0, 20'd5,      18'd7,       6'd4,  1'b1, 1'b1, EXP_UNDER, 1'b1};
    vecs[8]  = '{1'b1, 20'hFFFFF,  18'h3FFFF,   6'd63, 1'b0, 1'b0, 38'h3FFFEC0001, 1'b0};
    vecs[9]  = '{1'b0, 20'hFFFFF,  18'h3FFFF,   6'd63, 1'b1, 1'b0, EXP_BIG2, 1'b1};
    vecs[10] = '{1'b0, 20'd1,      18'd0,       6'd37, 1'b0, 1'b0, 38'h2000000000, 1'b1};
    vecs[11] = '{1'b0, 20'd3,      18'd0,       6'd37, 1'b1, 1'b0, EXP_CARRY, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; shift = '0; acc_en = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_shift = '0; s_acc_en = 1'b0; s_sub = 1'b0;
    model_z = '0;
    model_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset z_out", 64'(z_out), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset signed z_out", 64'(s_z_out), 64'd0);

    // Latency: captured at edge N, out_valid only after edge N+3.
    applyStimulus(1'b1, 20'd255, 18'd1, 6'd1, 1'b0, 1'b0, 38'd765, 1'b0);
    in_valid = 1'b0;
    checkOutput("latency N", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency N+1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency N+2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency N+3", 64'(out_valid), 64'd1);
    waitDrain("latency");

    // Vector table, applied back to back.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_reset) begin
        waitDrain("table");
        resetDut();
      end
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].shift,
                    vecs[i].acc_en, vecs[i].sub, vecs[i].z, vecs[i].ovf);
    end
    waitDrain("table end");

    // Idle: z_out must hold with in_valid low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle hold z_out", 64'(z_out), 64'(EXP_CARRY));

    // Reset with three beats in flight: none may emerge.
    applyStimulus(1'b1, 20'd7, 18'd9, 6'd2, 1'b0, 1'b0, 38'd0, 1'b0);
    applyStimulus(1'b1, 20'd8, 18'd9, 6'd2, 1'b1, 1'b0, 38'd0, 1'b0);
    applyStimulus(1'b1, 20'd9, 18'd9, 6'd2, 1'b1, 1'b0, 38'd0, 1'b0);
    resetDut();
    for (int i = 0; i < 5; i++) begin
      checkOutput("flush out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("flush z_out", 64'(z_out), 64'd0);
    checkOutput("flush overflow", 64'(overflow), 64'd0);
    applyStimulus(1'b1, 20'd1, 18'd1, 6'd0, 1'b1, 1'b0, 38'd2, 1'b0);
    waitDrain("post reset");

    // Random beats with gaps, checked against the reference model.
    resetDut();
    for (int i = 0; i < 60; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 3) == 0) ? A_W'($urandom()) : A_W'($urandom_range(0, 4095));
      rb  = ($urandom_range(0, 3) == 0) ? B_W'($urandom()) : B_W'($urandom_range(0, 4095));
      rs  = SHIFT_W'($urandom_range(0, 63));
      rae = 1'($urandom_range(0, 1));
      rsu = ($urandom_range(0, 4) == 0);
      ez  = '0;
      eo  = 1'b0;
      if (rv) modelBeat(ra, rb, rs, rae, rsu, ez, eo);
      applyStimulus(rv, ra, rb, rs, rae, rsu, ez, eo);
    end
    waitDrain("random");

    // Signed instance.
    resetDut();
    signedBeat("signed -14", 20'hFFFFE, 18'd3, 6'd2, 1'b0, 1'b0, 38'h3FFFFFFFF2, 1'b0);
    signedBeat("signed acc", 20'hFFFFE, 18'd3, 6'd2, 1'b1, 1'b0, 38'h3FFFFFFFE4, 1'b0);
    signedBeat("signed sub", 20'd1, 18'd1, 6'd0, 1'b1, 1'b1, 38'h3FFFFFFFE2, 1'b0);
    signedBeat("signed term ovf", 20'h7FFFF, 18'h1FFFF, 6'd18, 1'b0, 1'b0, EXP_S_OVF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
